// File: rtl/reg_file_param_if.sv
// Read/write/clear bus of the parametrised register file.
// The master is the datapath/control side; the slave is reg_file_param.
interface reg_file_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) ();
  logic [NUM_RD*ADDR_W-1:0] ra_i;
  logic [NUM_RD*DATA_W-1:0] rd_o;
  logic [ADDR_W-1:0]        wa_i;
  logic                     wren_i;
  logic [DATA_W-1:0]        wrdata_i;
  logic                     clr_i;
  logic                     busy_o;
  logic                     done_o;

  modport master (
    output ra_i, wa_i, wren_i, wrdata_i, clr_i,
    input  rd_o, busy_o, done_o
  );

  modport slave (
    input  ra_i, wa_i, wren_i, wrdata_i, clr_i,
    output rd_o, busy_o, done_o
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised multi-read, single-write register file with optional zero entry,
// optional write-to-read bypass and a sequential one-entry-per-cycle bulk-clear engine.
module reg_file_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic             clk_i,
  input logic             rst_ni,
  reg_file_param_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;
  logic              clr_en;
  logic [NUM_RD*DATA_W-1:0] rd;

  // A clear request in IDLE/DONE beats a same-cycle write; writes to a hardwired zero never land.
  assign wr_en  = bus.wren_i && (state_q != StClear) && !bus.clr_i &&
                  !((ZERO_REG != 0) && (bus.wa_i == '0));
  assign clr_en = (state_q == StClear);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.clr_i) begin
          state_d = StClear;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        if (bus.clr_i) begin
          state_d = StClear;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_en) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[bus.wa_i] <= bus.wrdata_i;
    end
  end

  always_comb begin
    rd = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if ((ZERO_REG != 0) && (bus.ra_i[p*ADDR_W +: ADDR_W] == '0)) begin
        rd[p*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && wr_en && (bus.wa_i == bus.ra_i[p*ADDR_W +: ADDR_W])) begin
        rd[p*DATA_W +: DATA_W] = bus.wrdata_i;
      end else begin
        rd[p*DATA_W +: DATA_W] = mem_q[bus.ra_i[p*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign bus.rd_o   = rd;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised successor to the core's 2-read/1-write register file. It has configurable data width, address width and read-port count, an optional hardwired-zero entry and optional write-to-read bypass. It adds a sequential bulk-clear engine (counter-driven FSM with busy/done handshake) so the multicycle control unit can scrub the architectural state without a full reset. It sits in the datapath in place of the fixed 32x32 register file.

Parameters:
DATA_W, 32, width of each register entry
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent combinational read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is an ordinary register
BYPASS, 1, 1 = a read of the address being written this cycle returns wrdata_i; 0 = returns stored value

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
ra_i  in  NUM_RD*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
rd_o  out  NUM_RD*DATA_W  read data; port p uses bits [p*DATA_W +: DATA_W]
wa_i  in  ADDR_W  write address
wren_i  in  1  write enable
wrdata_i  in  DATA_W  write data
clr_i  in  1  bulk-clear request, sampled on the rising edge
busy_o  out  1  clear in progress (registered)
done_o  out  1  one-cycle pulse when a clear completes (registered)

Behaviour:
- Reset: one clock, clk_i; reset is asynchronous and active-low on rst_ni. While rst_ni=0, all DEPTH entries are 0, the FSM is in IDLE, the counter is 0, and busy_o=0, done_o=0. rd_o then reads 0 because the array is 0.
- Reads: combinational, with no clock latency. rd_o[p] = entry[ra_i[p]].
  - ZERO_REG=1: ra=0 always yields 0.
  - BYPASS=1 and a write is accepted this cycle with wa_i==ra_i[p]: rd_o[p]=wrdata_i. With ZERO_REG=1 and wa_i=0 there is no bypass.
- Write accepted: wren_i=1 and state != CLEAR and not (clr_i=1 in IDLE/DONE). The entry updates at the rising edge.
  - ZERO_REG=1 and wa_i=0: the write is dropped.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE, clr_i=1 -> CLEAR. Counter <= 0, busy_o <= 1. A simultaneous wren_i is dropped (clear wins).
  - CLEAR, each edge: entry[cnt] <= 0 and cnt <= cnt+1. When cnt==DEPTH-1 -> DONE, busy_o <= 0, done_o <= 1.
  - DONE: lasts exactly one cycle, then done_o <= 0. Next state is CLEAR if clr_i=1, otherwise IDLE. Writes are accepted as in IDLE.
- Clear timing: clr_i sampled at edge N. busy_o is high from N until N+DEPTH. Entries 0..DEPTH-1 are zeroed at edges N+1..N+DEPTH respectively. done_o is high from N+DEPTH to N+DEPTH+1.
- During CLEAR:
  - clr_i is ignored (no restart).
  - wren_i is ignored.
  - Bypass is inactive.
  - Reads return the current partially cleared array contents.
- Counter width: ADDR_W bits. Wrap from DEPTH-1 never reaches a second pass because the FSM leaves CLEAR.
- Reset mid-clear: rst_ni=0 immediately zeroes everything, forces IDLE and drops busy_o. No done_o pulse is produced.
- Multiple read ports may address the same entry and all return identical data.
- Width rules: no arithmetic on data. Writes store wrdata_i unchanged (full DATA_W bits).

Test Plan:
1. Reset then read: rst_ni low then high; ra_i={2,0}, no writes -> rd_o={0,0}, busy_o=0, done_o=0.
2. Write/readback/bypass with defaults: write 32'h000000FF to x2, then ra_i port0=2 -> 32'h000000FF. Next, write 32'h00000FFF to x3 with ra_i port1=3 in the same cycle -> rd_o port1=32'h00000FFF before the edge (BYPASS=1). Same sequence with BYPASS=0 -> old value 0 until after the edge.
3. x0 protection: wren_i=1, wa_i=0, wrdata_i=32'hFFFFFFFF; ra_i port0=0 -> 0 in the same cycle and after. Entry 0 stays 0. With ZERO_REG=0, entry 0 reads 32'hFFFFFFFF after the edge.
4. Bulk clear, DEPTH=32: preload x1..x31 with their index, pulse clr_i at edge N -> busy_o=1 for 32 cycles. After edge N+6, x5=0 and x6=6. done_o is high for exactly one cycle after edge N+32. All entries are 0 afterwards. wren_i to x7 mid-clear leaves x7=0.
5. Collisions: clr_i and wren_i (x4, 32'hA5A5A5A5) in the same IDLE cycle -> the write is dropped and x4=0 after the clear. clr_i re-asserted during CLEAR -> no extra cycles; done_o still at N+32.
6. Reset mid-clear and parameter sweep:
   - rst_ni low at edge N+10 -> busy_o=0 immediately, no done_o, all entries 0.
   - Repeat scenarios 2 and 4 with DATA_W=16, ADDR_W=3, NUM_RD=3 -> clear takes 8 cycles and all three read ports are correct.
